// File: rtl/guvm_wb_responder.sv
// -----------------------------------------------------------------------------
// guvm_wb_responder
//
// Wishbone slave that sits on the Amber core's 128-bit Wishbone port and acts
// as its memory.
//   * Read cycles are served from a read FIFO. The stimulus side fills this
//     FIFO with 32-bit words. A read that finds the FIFO empty stalls. If no
//     word arrives within TIMEOUT cycles, the read ends with a bus error.
//   * Write cycles push {address, addressed 32-bit lane} into a show-ahead
//     capture FIFO. The result monitor drains this FIFO.
//
// Optional build macro:
//   GUVM_WB_LANE_SELECT_EN  - if defined, read data goes only into lane
//                             core_wb_adr[3:2] of rsp_wb_dat and the other
//                             lanes are 0. If undefined, the word is
//                             replicated into all four lanes.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   push_valid/ready   stimulus word handshake into the read FIFO
//   push_data          32-bit word pushed into the read FIFO
//   core_wb_*          core master outputs (adr, sel, we, cyc, stb, dat)
//   rsp_wb_dat/ack/err responses returned to the core
//   cap_valid/ready    capture FIFO handshake towards the monitor
//   cap_adr/cap_data   head entry of the capture FIFO
//   rd_level           read FIFO occupancy
// -----------------------------------------------------------------------------
module guvm_wb_responder #(
  parameter int RD_DEPTH  = 8,
  parameter int CAP_DEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [31:0]                 push_data,
  input  logic [31:0]                 core_wb_adr,
  input  logic [15:0]                 core_wb_sel,
  input  logic                        core_wb_we,
  input  logic                        core_wb_cyc,
  input  logic                        core_wb_stb,
  input  logic [127:0]                core_wb_dat,
  output logic [127:0]                rsp_wb_dat,
  output logic                        rsp_wb_ack,
  output logic                        rsp_wb_err,
  output logic                        cap_valid,
  input  logic                        cap_ready,
  output logic [31:0]                 cap_adr,
  output logic [31:0]                 cap_data,
  output logic [$clog2(RD_DEPTH):0]   rd_level
);

  localparam int RD_AW   = $clog2(RD_DEPTH);
  localparam int RD_LW   = RD_AW + 1;
  localparam int CAP_AW  = $clog2(CAP_DEPTH);
  localparam int CAP_LW  = CAP_AW + 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } cap_entry_t;

  // Byte selects are ignored on purpose: the write lane is chosen by
  // core_wb_adr[3:2] alone.
  logic unused_sel;
  assign unused_sel = ^core_wb_sel;

  logic [1:0]         state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               rd_pop, cap_push;
  logic               set_ack, set_err;
  logic               req;

  assign req = core_wb_cyc & core_wb_stb;

  // ---------------------------------------------------------------------------
  // Read FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      rd_mem [RD_DEPTH];
  logic [RD_AW-1:0] rd_wr_ptr, rd_rd_ptr;
  logic [RD_LW-1:0] rd_count, rd_count_d;
  logic             push_ready_q;
  logic             rd_push, rd_empty;
  logic [31:0]      rd_head;

  assign rd_push    = push_valid & push_ready_q;
  assign rd_empty   = (rd_count == '0);
  assign rd_head    = rd_mem[rd_rd_ptr];
  assign push_ready = push_ready_q;
  assign rd_level   = rd_count;

  always_comb begin
    // NOTE: each always_comb output gets a default first, so no path through the block can infer a latch.
    rd_count_d = rd_count;
    case ({rd_push, rd_pop})
      2'b10:   rd_count_d = rd_count + RD_LW'(1);
      2'b01:   rd_count_d = rd_count - RD_LW'(1);
      default: rd_count_d = rd_count;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every flop samples its inputs before any flop changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wr_ptr    <= '0;
      rd_rd_ptr    <= '0;
      rd_count     <= '0;
      push_ready_q <= 1'b1;
    end else begin
      if (rd_push) rd_wr_ptr <= rd_wr_ptr + RD_AW'(1);
      if (rd_pop)  rd_rd_ptr <= rd_rd_ptr + RD_AW'(1);
      rd_count     <= rd_count_d;
      // push_ready is registered from the next occupancy. A push is therefore
      // never offered when the FIFO is full.
      push_ready_q <= (rd_count_d != RD_LW'(RD_DEPTH));
    end
  end

  // NOTE: the storage array has no reset. Emptiness is tracked by the pointers and the count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wr_ptr] <= push_data;
  end

  // Read data returned to the core.
  logic [127:0] rd_resp_dat;
`ifdef GUVM_WB_LANE_SELECT_EN
  always_comb begin
    rd_resp_dat = '0;
    case (core_wb_adr[3:2])
      2'd0:    rd_resp_dat[31:0]   = rd_head;
      2'd1:    rd_resp_dat[63:32]  = rd_head;
      2'd2:    rd_resp_dat[95:64]  = rd_head;
      default: rd_resp_dat[127:96] = rd_head;
    endcase
  end
`else
  assign rd_resp_dat = {4{rd_head}};
`endif

  // ---------------------------------------------------------------------------
  // Capture FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  cap_entry_t        cap_mem [CAP_DEPTH];
  logic [CAP_AW-1:0] cap_wr_ptr, cap_rd_ptr;
  logic [CAP_LW-1:0] cap_count;
  logic              cap_pop, cap_full;
  logic [31:0]       wr_lane;
  cap_entry_t        cap_head;

  assign cap_valid = (cap_count != '0);
  assign cap_full  = (cap_count == CAP_LW'(CAP_DEPTH));
  assign cap_pop   = cap_valid & cap_ready;
  assign cap_head  = cap_mem[cap_rd_ptr];
  // Drive 0 while empty so the outputs never expose uninitialised storage.
  assign cap_adr   = cap_valid ? cap_head.adr  : '0;
  assign cap_data  = cap_valid ? cap_head.data : '0;

  always_comb begin
    wr_lane = '0;
    case (core_wb_adr[3:2])
      2'd0:    wr_lane = core_wb_dat[31:0];
      2'd1:    wr_lane = core_wb_dat[63:32];
      2'd2:    wr_lane = core_wb_dat[95:64];
      default: wr_lane = core_wb_dat[127:96];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wr_ptr <= '0;
      cap_rd_ptr <= '0;
      cap_count  <= '0;
    end else begin
      if (cap_push) cap_wr_ptr <= cap_wr_ptr + CAP_AW'(1);
      if (cap_pop)  cap_rd_ptr <= cap_rd_ptr + CAP_AW'(1);
      case ({cap_push, cap_pop})
        2'b10:   cap_count <= cap_count + CAP_LW'(1);
        2'b01:   cap_count <= cap_count - CAP_LW'(1);
        default: cap_count <= cap_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap_push) cap_mem[cap_wr_ptr] <= '{adr: core_wb_adr, data: wr_lane};
  end

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    rd_pop   = 1'b0;
    cap_push = 1'b0;
    set_ack  = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!core_wb_we) begin
            if (!rd_empty) begin
              rd_pop  = 1'b1;
              set_ack = 1'b1;
              state_d = ST_RESP;
            end else begin
              stall_d = '0;
              state_d = ST_RD_WAIT;
            end
          end else if (!cap_full) begin
            cap_push = 1'b1;
            set_ack  = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // A master that abandons the cycle gets no response and no word is
        // consumed.
        if (!core_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (!rd_empty) begin
          rd_pop  = 1'b1;
          set_ack = 1'b1;
          state_d = ST_RESP;
        end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = ST_RESP;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_WR_WAIT: begin
        // Writes wait for capture space indefinitely.
        if (!core_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (!cap_full) begin
          cap_push = 1'b1;
          set_ack  = 1'b1;
          state_d  = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;  // ST_RESP: the ack/err pulse lasts one cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stall_q    <= '0;
      rsp_wb_ack <= 1'b0;
      rsp_wb_err <= 1'b0;
      rsp_wb_dat <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      rsp_wb_ack <= set_ack;
      rsp_wb_err <= set_err;
      // Read data is loaded only on a pop. Write acks and idle cycles leave
      // the previous value in place, and an error forces 0.
      if (rd_pop)       rsp_wb_dat <= rd_resp_dat;
      else if (set_err) rsp_wb_dat <= '0;
    end
  end

endmodule

// File: tb/tb_guvm_wb_responder.sv
// -----------------------------------------------------------------------------
// tb_guvm_wb_responder
//
// Self-checking bench for guvm_wb_responder using its default parameters.
// The expected behaviour comes from a transaction-level model: a queue of
// pending read words, a queue of captured write entries, and fixed response
// latencies.
// -----------------------------------------------------------------------------
module tb_guvm_wb_responder;

  localparam int RD_DEPTH  = 8;
  localparam int CAP_DEPTH = 8;
  localparam int TIMEOUT   = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push_valid;
  logic         push_ready;
  logic [31:0]  push_data;
  logic [31:0]  core_wb_adr;
  logic [15:0]  core_wb_sel;
  logic         core_wb_we;
  logic         core_wb_cyc;
  logic         core_wb_stb;
  logic [127:0] core_wb_dat;
  logic [127:0] rsp_wb_dat;
  logic         rsp_wb_ack;
  logic         rsp_wb_err;
  logic         cap_valid;
  logic         cap_ready;
  logic [31:0]  cap_adr;
  logic [31:0]  cap_data;
  logic [3:0]   rd_level;

  guvm_wb_responder #(
    .RD_DEPTH (RD_DEPTH),
    .CAP_DEPTH(CAP_DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .core_wb_adr(core_wb_adr),
    .core_wb_sel(core_wb_sel),
    .core_wb_we (core_wb_we),
    .core_wb_cyc(core_wb_cyc),
    .core_wb_stb(core_wb_stb),
    .core_wb_dat(core_wb_dat),
    .rsp_wb_dat (rsp_wb_dat),
    .rsp_wb_ack (rsp_wb_ack),
    .rsp_wb_err (rsp_wb_err),
    .cap_valid  (cap_valid),
    .cap_ready  (cap_ready),
    .cap_adr    (cap_adr),
    .cap_data   (cap_data),
    .rd_level   (rd_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  logic [31:0] rd_model [$];
  ent_t        cap_model [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge. Outputs are sampled there and
  // inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read data for a word returned at address adr.
  function automatic logic [127:0] exp_rd(input logic [31:0] w, input logic [31:0] adr);
    logic [127:0] r;
`ifdef GUVM_WB_LANE_SELECT_EN
    r = '0;
    r[32*int'(adr[3:2]) +: 32] = w;
`else
    r = {4{w}};
    if (adr[0] === 1'bx) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] lane_of(input logic [127:0] d, input logic [31:0] adr);
    return d[32*int'(adr[3:2]) +: 32];
  endfunction

  task automatic push_word(input logic [31:0] w);
    push_valid = 1'b1;
    push_data  = w;
    if (push_ready) rd_model.push_back(w);
    tick();
    push_valid = 1'b0;
  endtask

  // One complete bus cycle. The task holds cyc/stb until ack or err is seen,
  // or until bound cycles have passed. It then drops them and waits one more
  // cycle, so the responder is back in IDLE before the next operation.
  task automatic wb_op(input logic we, input logic [31:0] adr, input logic [127:0] wdat,
                       input int bound, output int lat, output logic got_ack,
                       output logic got_err, output logic [127:0] rdat, output logic resp_after);
    core_wb_we  = we;
    core_wb_adr = adr;
    core_wb_dat = wdat;
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    lat = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    rdat = '0;
    while (lat < bound && !got_ack && !got_err) begin
      tick();
      lat++;
      got_ack = rsp_wb_ack;
      got_err = rsp_wb_err;
      rdat    = rsp_wb_dat;
    end
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    core_wb_we  = 1'b0;
    tick();
    resp_after = rsp_wb_ack | rsp_wb_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic         a, e, after;
    logic [127:0] d;
    logic [31:0]  w, adr;
    logic [127:0] wdat;
    int           seen;
    ent_t         ent;

    rst_n       = 1'b0;
    push_valid  = 1'b0;
    push_data   = '0;
    core_wb_adr = '0;
    core_wb_sel = '0;
    core_wb_we  = 1'b0;
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    core_wb_dat = '0;
    cap_ready   = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",        rsp_wb_ack, 0);
    check("rst_err",        rsp_wb_err, 0);
    check("rst_dat",        rsp_wb_dat, 0);
    check("rst_push_ready", push_ready, 1);
    check("rst_cap_valid",  cap_valid,  0);
    check("rst_cap_adr",    cap_adr,    0);
    check("rst_cap_data",   cap_data,   0);
    check("rst_rd_level",   rd_level,   0);
    rst_n = 1'b1;
    tick();

    // ---- read with a word already queued: ack one cycle after the request ----
    push_word(32'hE3A01005);
    check("t1_level_1", rd_level, 1);
    wb_op(1'b0, 32'h0, '0, 10, lat, a, e, d, after);
    check("t1_ack",       a, 1);
    check("t1_latency",   lat, 1);
    check("t1_data",      d, exp_rd(32'hE3A01005, 32'h0));
    check("t1_pulse",     after, 0);
    check("t1_level_0",   rd_level, 0);
    check("t1_dat_hold",  rsp_wb_dat, exp_rd(32'hE3A01005, 32'h0));
    void'(rd_model.pop_front());

    // ---- read on an empty FIFO, word pushed five cycles later ----
    core_wb_adr = 32'h4;
    core_wb_we  = 1'b0;
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      seen += int'(rsp_wb_ack | rsp_wb_err);
    end
    check("t2_no_early_resp", seen, 0);
    push_word(32'hE0812002);
    check("t2_word_visible_no_ack", rsp_wb_ack, 0);
    check("t2_level_1", rd_level, 1);
    tick();
    check("t2_ack",     rsp_wb_ack, 1);
    check("t2_data",    rsp_wb_dat, exp_rd(32'hE0812002, 32'h4));
    check("t2_level_0", rd_level, 0);
    void'(rd_model.pop_front());
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    tick();
    check("t2_pulse", rsp_wb_ack, 0);

    // ---- starved read: counter runs 0..TIMEOUT-1 in RD_WAIT, then err ----
    wb_op(1'b0, 32'h8, '0, TIMEOUT + 10, lat, a, e, d, after);
    check("t3_err",      e, 1);
    check("t3_no_ack",   a, 0);
    check("t3_latency",  lat, TIMEOUT + 1);
    check("t3_err_dat",  d, 0);
    check("t3_pulse",    after, 0);
    check("t3_level",    rd_level, 0);

    // ---- fill the capture FIFO, ninth write stalls until space appears ----
    for (int i = 0; i < CAP_DEPTH; i++) begin
      adr  = $urandom() & 32'hFFFF_FFFC;
      wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
      wb_op(1'b1, adr, wdat, 10, lat, a, e, d, after);
      check("t4_write_ack_lat1", {31'd0, a} + 128'(lat), 2);
      cap_model.push_back('{adr: adr, data: lane_of(wdat, adr)});
    end
    check("t4_cap_valid", cap_valid, 1);
    check("t4_head_adr",  cap_adr,  cap_model[0].adr);
    check("t4_head_data", cap_data, cap_model[0].data);

    wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_wb_adr = 32'h14;
    core_wb_dat = wdat;
    core_wb_we  = 1'b1;
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    seen = 0;
    repeat (3) begin
      tick();
      seen += int'(rsp_wb_ack | rsp_wb_err);
    end
    check("t4_wr_wait_no_ack", seen, 0);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    void'(cap_model.pop_front());
    check("t4_no_ack_on_pop_cycle", rsp_wb_ack, 0);
    tick();
    check("t4_wr9_ack", rsp_wb_ack, 1);
    cap_model.push_back('{adr: 32'h14, data: wdat[63:32]});
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    core_wb_we  = 1'b0;
    tick();

    // Drain in FIFO order. The final entry is the stalled write at 0x14.
    cap_ready = 1'b1;
    for (int i = 0; i < CAP_DEPTH + 2 && cap_model.size() > 0; i++) begin
      ent = cap_model.pop_front();
      check("t4_drain_valid", cap_valid, 1);
      check("t4_drain_adr",   cap_adr,  ent.adr);
      check("t4_drain_data",  cap_data, ent.data);
      tick();
    end
    cap_ready = 1'b0;
    check("t4_drained", cap_valid, 0);

    // ---- read FIFO full, blocked push, simultaneous push+pop across wrap ----
    for (int i = 0; i < RD_DEPTH; i++) push_word($urandom());
    check("t5_full_ready", push_ready, 0);
    check("t5_full_level", rd_level, RD_DEPTH);
    push_word(32'hDEAD_BEEF);  // refused: the model only queues on push_ready
    check("t5_blocked_level", rd_level, RD_DEPTH);

    adr = 32'h0000_0100 | (32'($urandom_range(0, 3)) << 2);
    wb_op(1'b0, adr, '0, 10, lat, a, e, d, after);
    check("t5_first_pop", d, exp_rd(rd_model[0], adr));
    void'(rd_model.pop_front());
    check("t5_level_7", rd_level, RD_DEPTH - 1);
    check("t5_ready_7", push_ready, 1);

    w   = $urandom();
    adr = 32'h0000_0200 | (32'($urandom_range(0, 3)) << 2);
    push_valid  = 1'b1;
    push_data   = w;
    core_wb_adr = adr;
    core_wb_we  = 1'b0;
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    tick();
    check("t5_both_ack",   rsp_wb_ack, 1);
    check("t5_both_data",  rsp_wb_dat, exp_rd(rd_model[0], adr));
    check("t5_both_level", rd_level, RD_DEPTH - 1);
    void'(rd_model.pop_front());
    rd_model.push_back(w);
    push_valid  = 1'b0;
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    tick();

    for (int i = 0; i < RD_DEPTH + 2 && rd_model.size() > 0; i++) begin
      adr = ($urandom() & 32'hFFFF_FFF0) | (32'(i % 4) << 2);
      wb_op(1'b0, adr, '0, 10, lat, a, e, d, after);
      check("t5_order", d, exp_rd(rd_model[0], adr));
      void'(rd_model.pop_front());
    end
    check("t5_empty_level", rd_level, 0);
    check("t5_empty_ready", push_ready, 1);

    // ---- reset while a read is stalled ----
    wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
    wb_op(1'b1, 32'h0000_0040, wdat, 10, lat, a, e, d, after);
    check("t6_cap_valid_before", cap_valid, 1);
    push_word(32'h1234_5678);
    core_wb_adr = 32'h0;
    core_wb_we  = 1'b0;
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    tick();
    void'(rd_model.pop_front());
    check("t6_pre_ack", rsp_wb_ack, 1);
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    tick();
    core_wb_cyc = 1'b1;
    core_wb_stb = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack",       rsp_wb_ack, 0);
    check("t6_rst_err",       rsp_wb_err, 0);
    check("t6_rst_cap_valid", cap_valid,  0);
    check("t6_rst_dat",       rsp_wb_dat, 0);
    core_wb_cyc = 1'b0;
    core_wb_stb = 1'b0;
    cap_model.delete();
    rd_model.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_level_after", rd_level, 0);
    check("t6_ready_after", push_ready, 1);
    seen = 0;
    repeat (TIMEOUT + 5) begin
      tick();
      seen += int'(rsp_wb_ack | rsp_wb_err);
    end
    check("t6_no_stray_resp", seen, 0);
    w = $urandom();
    push_word(w);
    wb_op(1'b0, 32'hC, '0, 10, lat, a, e, d, after);
    check("t6_idle_read_lat", lat, 1);
    check("t6_idle_read_dat", d, exp_rd(w, 32'hC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
